// File: rtl/usb_reg_bridge.sv
// USB parallel-bus to register-file bridge in the clk_usb domain.
// Synchronises the bus strobes, then issues single-cycle register requests.
module usb_reg_bridge #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pSYNC_STAGES  = 2,
    parameter int pRD_HOLD      = 3
) (
    input  logic                                 clk_usb,
    input  logic                                 reset_n,
    input  logic [pADDR_WIDTH-1:0]               usb_addr,
    input  logic [7:0]                           usb_din,
    output logic [7:0]                           usb_dout,
    output logic                                 usb_isout,
    input  logic                                 usb_rdn,
    input  logic                                 usb_wrn,
    input  logic                                 usb_cen,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    output logic [7:0]                           reg_datao,
    input  logic [7:0]                           reg_datai,
    output logic                                 reg_read,
    output logic                                 reg_write,
    output logic                                 reg_addrvalid,
    output logic                                 bus_err
);

    localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int CW = $clog2(pRD_HOLD + 1);
    localparam int SS = pSYNC_STAGES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_ACTIVE,
        S_RD_HOLD,
        S_WR
    } state_e;

    state_e            state_q, state_d;
    logic [SS-1:0]     rdn_sync_q, rdn_sync_d;
    logic [SS-1:0]     wrn_sync_q, wrn_sync_d;
    logic [SS-1:0]     cen_sync_q, cen_sync_d;
    logic              rdn_d_q, rdn_d_d;
    logic              wrn_d_q, wrn_d_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [pBYTECNT_SIZE-1:0] bcnt_q, bcnt_d;
    logic [7:0]        datao_q, datao_d;
    logic [7:0]        dout_q, dout_d;
    logic              isout_q, isout_d;
    logic              err_q, err_d;

    logic              rdn_s, wrn_s, cen_s;
    logic              rd_edge, wr_edge;
    logic              in_read;

    assign rdn_s   = rdn_sync_q[SS-1];
    assign wrn_s   = wrn_sync_q[SS-1];
    assign cen_s   = cen_sync_q[SS-1];
    assign rd_edge = !rdn_s && rdn_d_q && !cen_s;
    assign wr_edge = !wrn_s && wrn_d_q && !cen_s;
    assign in_read = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT) ||
                     (state_q == S_RD_ACTIVE) || (state_q == S_RD_HOLD);

    always_comb begin
        rdn_sync_d = {rdn_sync_q[SS-2:0], usb_rdn};
        wrn_sync_d = {wrn_sync_q[SS-2:0], usb_wrn};
        cen_sync_d = {cen_sync_q[SS-2:0], usb_cen};
        rdn_d_d    = rdn_s;
        wrn_d_d    = wrn_s;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        bcnt_d  = bcnt_q;
        datao_d = datao_q;
        dout_d  = dout_q;
        err_d   = err_q;

        // A write strobe cannot be serviced while the bus is being read
        if (wr_edge && in_read) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (rd_edge && wr_edge) begin
                    err_d = 1'b1;
                end else if (rd_edge) begin
                    addr_d  = usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
                    bcnt_d  = usb_addr[pBYTECNT_SIZE-1:0];
                    state_d = S_RD_REQ;
                end else if (wr_edge) begin
                    addr_d  = usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
                    bcnt_d  = usb_addr[pBYTECNT_SIZE-1:0];
                    datao_d = usb_din;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            S_RD_REQ: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                dout_d = reg_datai;
                if (!rdn_s) begin
                    state_d = S_RD_ACTIVE;
                end else begin
                    cnt_d   = CW'(pRD_HOLD);
                    state_d = S_RD_HOLD;
                end
            end
            S_RD_ACTIVE: begin
                // The release cycle itself is the first cycle of the hold window
                if (rdn_s) begin
                    cnt_d   = CW'(pRD_HOLD - 1);
                    state_d = (pRD_HOLD == 1) ? S_IDLE : S_RD_HOLD;
                end
            end
            S_RD_HOLD: begin
                if (rd_edge) begin
                    addr_d  = usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
                    bcnt_d  = usb_addr[pBYTECNT_SIZE-1:0];
                    state_d = S_RD_REQ;
                end else if (cnt_q <= CW'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        isout_d = (state_d == S_RD_REQ) || (state_d == S_RD_WAIT) ||
                  (state_d == S_RD_ACTIVE) || (state_d == S_RD_HOLD);
    end

    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rdn_sync_q <= '1;
            wrn_sync_q <= '1;
            cen_sync_q <= '1;
            rdn_d_q    <= 1'b1;
            wrn_d_q    <= 1'b1;
            cnt_q      <= '0;
            addr_q     <= '0;
            bcnt_q     <= '0;
            datao_q    <= '0;
            dout_q     <= '0;
            isout_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdn_sync_q <= rdn_sync_d;
            wrn_sync_q <= wrn_sync_d;
            cen_sync_q <= cen_sync_d;
            rdn_d_q    <= rdn_d_d;
            wrn_d_q    <= wrn_d_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            bcnt_q     <= bcnt_d;
            datao_q    <= datao_d;
            dout_q     <= dout_d;
            isout_q    <= isout_d;
            err_q      <= err_d;
        end
    end

    assign usb_dout      = dout_q;
    assign usb_isout     = isout_q;
    assign reg_address   = addr_q;
    assign reg_bytecnt   = bcnt_q;
    assign reg_datao     = datao_q;
    assign reg_read      = (state_q == S_RD_REQ);
    assign reg_write     = (state_q == S_WR);
    assign reg_addrvalid = (state_q != S_IDLE);
    assign bus_err       = err_q;

endmodule

// File: tb/tb_usb_reg_bridge.sv
// Directed bench for usb_reg_bridge with default parameters.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_usb_reg_bridge;

    logic        clk_usb = 1'b0;
    logic        reset_n;
    logic [20:0] usb_addr;
    logic [7:0]  usb_din;
    logic [7:0]  usb_dout;
    logic        usb_isout;
    logic        usb_rdn;
    logic        usb_wrn;
    logic        usb_cen;
    logic [13:0] reg_address;
    logic [6:0]  reg_bytecnt;
    logic [7:0]  reg_datao;
    logic [7:0]  reg_datai;
    logic        reg_read;
    logic        reg_write;
    logic        reg_addrvalid;
    logic        bus_err;

    int vectors = 0;
    int errors  = 0;
    int rd_cnt  = 0;
    int wr_cnt  = 0;
    logic both_seen = 1'b0;
    logic long_seen = 1'b0;
    logic prev_rd   = 1'b0;
    logic prev_wr   = 1'b0;
    int rd0;
    int wr0;

    always #5 clk_usb = ~clk_usb;

    usb_reg_bridge dut (
        .clk_usb       (clk_usb),
        .reset_n       (reset_n),
        .usb_addr      (usb_addr),
        .usb_din       (usb_din),
        .usb_dout      (usb_dout),
        .usb_isout     (usb_isout),
        .usb_rdn       (usb_rdn),
        .usb_wrn       (usb_wrn),
        .usb_cen       (usb_cen),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .reg_datao     (reg_datao),
        .reg_datai     (reg_datai),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .reg_addrvalid (reg_addrvalid),
        .bus_err       (bus_err)
    );

    // Request pulse bookkeeping
    always @(negedge clk_usb) begin
        if (reg_read) rd_cnt <= rd_cnt + 1;
        if (reg_write) wr_cnt <= wr_cnt + 1;
        if (reg_read && reg_write) both_seen <= 1'b1;
        if ((reg_read && prev_rd) || (reg_write && prev_wr)) long_seen <= 1'b1;
        prev_rd <= reg_read;
        prev_wr <= reg_write;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_usb);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (reg_addrvalid && n < 40) begin
            step();
            n++;
        end
        chk(tag, {31'd0, reg_addrvalid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        usb_rdn   = 1'b1;
        usb_wrn   = 1'b1;
        usb_cen   = 1'b0;
        usb_addr  = '0;
        usb_din   = '0;
        reg_datai = '0;
        step(3);
        chk("rst_outs", {8'd0, usb_dout, usb_isout, reg_read, reg_write,
                         reg_addrvalid, bus_err, 3'd0, reg_datao}, 32'd0);
        chk("rst_addr", {11'd0, reg_address, reg_bytecnt}, 32'd0);
        reset_n = 1'b1;
        step(2);

        // Write 0x85 <= 0xA5
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        usb_addr = 21'h000085;
        usb_din  = 8'hA5;
        usb_wrn  = 1'b0;
        step(2);
        chk("wr_e", {31'd0, reg_write}, 32'd0);
        step();
        chk("wr_pulse", {31'd0, reg_write}, 32'd1);
        chk("wr_addr", {18'd0, reg_address}, 32'h1);
        chk("wr_bcnt", {25'd0, reg_bytecnt}, 32'h05);
        chk("wr_data", {24'd0, reg_datao}, 32'hA5);
        step();
        chk("wr_done", {30'd0, reg_write, reg_addrvalid}, 32'd0);
        step(5);
        usb_wrn = 1'b1;
        step(4);
        chk("wr_count", wr_cnt - wr0, 32'd1);
        chk("wr_no_rd", rd_cnt - rd0, 32'd0);

        // Long read of 0x102
        rd0 = rd_cnt;
        usb_addr  = 21'h000102;
        reg_datai = 8'h3C;
        usb_rdn   = 1'b0;
        step(2);
        chk("rd_pre", {31'd0, usb_isout}, 32'd0);
        step();
        chk("rd_req", {30'd0, reg_read, usb_isout}, 32'h3);
        chk("rd_addr", {18'd0, reg_address}, 32'h2);
        chk("rd_bcnt", {25'd0, reg_bytecnt}, 32'h02);
        step();
        chk("rd_wait", {30'd0, reg_read, usb_isout}, 32'h1);
        step();
        chk("rd_dout", {24'd0, usb_dout}, 32'h3C);
        step(5);
        usb_rdn   = 1'b1;
        reg_datai = 8'h00;
        step(4);
        chk("rd_hold", {31'd0, usb_isout}, 32'd1);
        step();
        chk("rd_fall", {31'd0, usb_isout}, 32'd0);
        chk("rd_keep", {24'd0, usb_dout}, 32'h3C);
        chk("rd_count", rd_cnt - rd0, 32'd1);
        step(3);

        // Short read of 0x203
        rd0 = rd_cnt;
        usb_addr  = 21'h000203;
        reg_datai = 8'h5A;
        usb_rdn   = 1'b0;
        step();
        usb_rdn = 1'b1;
        step();
        chk("sh_pre", {31'd0, usb_isout}, 32'd0);
        step();
        chk("sh_req", {30'd0, reg_read, usb_isout}, 32'h3);
        chk("sh_addr", {11'd0, reg_address, reg_bytecnt}, {11'd0, 14'h4, 7'h03});
        step(2);
        chk("sh_dout", {23'd0, usb_isout, usb_dout}, {23'd0, 1'b1, 8'h5A});
        step(2);
        chk("sh_last", {31'd0, usb_isout}, 32'd1);
        step();
        chk("sh_fall", {30'd0, usb_isout, reg_addrvalid}, 32'd0);
        chk("sh_count", rd_cnt - rd0, 32'd1);
        step(3);

        // Second read edge while the first is in its hold window
        rd0 = rd_cnt;
        usb_addr  = 21'h000381;
        reg_datai = 8'h11;
        usb_rdn   = 1'b0;
        step();
        usb_rdn = 1'b1;
        step(2);
        chk("bb_req1", {30'd0, reg_read, usb_isout}, 32'h3);
        step();
        usb_rdn  = 1'b0;
        usb_addr = 21'h000480;
        chk("bb_e4", {31'd0, usb_isout}, 32'd1);
        step();
        chk("bb_dout1", {23'd0, usb_isout, usb_dout}, {23'd0, 1'b1, 8'h11});
        reg_datai = 8'h22;
        step();
        chk("bb_e6", {30'd0, reg_read, usb_isout}, 32'h1);
        step();
        chk("bb_req2", {30'd0, reg_read, usb_isout}, 32'h3);
        chk("bb_addr2", {11'd0, reg_address, reg_bytecnt}, {11'd0, 14'h9, 7'h00});
        step();
        chk("bb_e8", {30'd0, reg_read, usb_isout}, 32'h1);
        step();
        chk("bb_dout2", {23'd0, usb_isout, usb_dout}, {23'd0, 1'b1, 8'h22});
        usb_rdn = 1'b1;
        wait_idle("bb_idle");
        chk("bb_count", rd_cnt - rd0, 32'd2);
        step(3);

        // Reset in the middle of a read
        usb_addr  = 21'h000085;
        reg_datai = 8'h77;
        usb_rdn   = 1'b0;
        step(6);
        chk("mr_active", {23'd0, usb_isout, usb_dout}, {23'd0, 1'b1, 8'h77});
        reset_n = 1'b0;
        rd0 = rd_cnt;
        step();
        chk("mr_outs", {8'd0, usb_dout, usb_isout, reg_read, reg_write,
                        reg_addrvalid, bus_err, 3'd0, reg_datao}, 32'd0);
        chk("mr_addr", {11'd0, reg_address, reg_bytecnt}, 32'd0);
        usb_rdn = 1'b1;
        step(2);
        chk("mr_hold", {30'd0, reg_read, reg_addrvalid}, 32'd0);
        reset_n = 1'b1;
        step(4);
        chk("mr_after", {31'd0, reg_addrvalid}, 32'd0);
        chk("mr_no_rd", rd_cnt - rd0, 32'd0);

        // Chip enable deasserted masks all strobes
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        usb_cen = 1'b1;
        step(3);
        for (int i = 0; i < 4; i++) begin
            usb_rdn = i[0];
            usb_wrn = ~i[0];
            step(3);
            usb_rdn = 1'b0;
            usb_wrn = 1'b0;
            step(3);
            usb_rdn = 1'b1;
            usb_wrn = 1'b1;
            step(3);
        end
        chk("cen_reqs", (rd_cnt - rd0) + (wr_cnt - wr0), 32'd0);
        chk("cen_err", {31'd0, bus_err}, 32'd0);
        usb_cen = 1'b0;
        step(4);

        // Read and write strobes falling together
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        usb_addr = 21'h000010;
        usb_rdn  = 1'b0;
        usb_wrn  = 1'b0;
        step(3);
        chk("both_err", {29'd0, bus_err, reg_read, reg_write}, 32'h4);
        chk("both_idle", {31'd0, reg_addrvalid}, 32'd0);
        usb_rdn = 1'b1;
        usb_wrn = 1'b1;
        step(8);
        chk("both_noreq", (rd_cnt - rd0) + (wr_cnt - wr0), 32'd0);
        chk("err_sticky", {31'd0, bus_err}, 32'd1);
        reset_n = 1'b0;
        step();
        chk("err_clear", {31'd0, bus_err}, 32'd0);
        reset_n = 1'b1;
        step(2);

        chk("req_overlap", {31'd0, both_seen}, 32'd0);
        chk("req_width", {31'd0, long_seen}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
